// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, frame width and bit-timer sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Width of a counter that must reach 2*half_bit-1 (one full bit period).
    function automatic int timer_w(input int half_bit);
        return $clog2(2 * half_bit);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: rxd synchronizer, frame FSM, bit timer and LSB-first shift register.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | line idle, waiting for synchronized rxd to go low
//  ST_START | timing to mid start bit; high there means a glitch, go idle
//  ST_DATA  | one sample per bit period, 8 bits LSB first
//  ST_STOP  | sample mid stop bit, push or flag, and return to idle at once
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid,
    output logic                 ferr_pulse
);

    localparam int TW = timer_w(CLK_PER_HALF_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_TC  = TW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0] FULL_TC  = TW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 sync1;
    logic                 sync2;
    uart_state_t          state;
    uart_state_t          state_next;
    logic                 sample;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state, sample strobe and the one-cycle result pulses.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        byte_valid = 1'b0;
        ferr_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!sync2) state_next = ST_START;
            end
            ST_START: begin
                if (timer == HALF_TC) begin
                    sample     = 1'b1;
                    state_next = sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer == FULL_TC) begin
                    sample = 1'b1;
                    if (bit_idx == LAST_BIT) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (timer == FULL_TC) begin
                    sample     = 1'b1;
                    byte_valid = sync2;
                    ferr_pulse = !sync2;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bit timer restarts on every state change and every sample; datapath shifts on data samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_next != state || sample) timer <= '0;
            else                               timer <= timer + TW'(1);
            if (state == ST_START && sample) bit_idx <= '0;
            if (state == ST_DATA && sample) begin
                shreg   <= {sync2, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + BW'(1);
            end
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver top: receive core feeding a first-word-fall-through byte FIFO,
// with occupancy count and sticky framing/overflow flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int ADDR_W           = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [ADDR_W:0]      level,
    output logic                 frame_err,
    output logic                 overflow,
    input  logic                 clr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_valid;
    logic                 ferr_pulse;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;

    uart_rx_core #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_core (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .ferr_pulse (ferr_pulse)
    );

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign rvalid  = (level != '0);
    assign pop     = rvalid & rready;
    assign push_ok = byte_valid & ((level != LVL_FULL) | pop);
    assign drop    = byte_valid & ~push_ok;
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so rdata reads zero after an abort.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    // Pointers wrap naturally; level moves only when exactly one of push/pop happens.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push_ok && !pop)      level <= level + (ADDR_W+1)'(1);
            else if (pop && !push_ok) level <= level - (ADDR_W+1)'(1);
        end
    end

    // Sticky flags: a new event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (ferr_pulse)   frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (drop)         overflow  <= 1'b1;
            else if (clr_err) overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: fast instance (half bit = 8) for function,
// default-timing instance (half bit = 434) for end-to-end latency.
module tb_uart_rx_fifo;

    localparam int H  = 8;
    localparam int HS = 434;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic       rready = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rdata;
    logic       rvalid;
    logic [4:0] level;
    logic       frame_err;
    logic       overflow;

    logic       rxd_slow = 1'b1;
    logic       rready_slow = 1'b0;
    logic [7:0] rdata_slow;
    logic       rvalid_slow;
    logic [4:0] level_slow;
    logic       frame_err_slow;
    logic       overflow_slow;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .ADDR_W(4)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .level(level), .frame_err(frame_err),
        .overflow(overflow), .clr_err(clr_err)
    );

    uart_rx_fifo #(.CLK_PER_HALF_BIT(HS), .ADDR_W(4)) dut_slow (
        .clk(clk), .rstn(rstn), .rxd(rxd_slow), .rdata(rdata_slow), .rvalid(rvalid_slow),
        .rready(rready_slow), .level(level_slow), .frame_err(frame_err_slow),
        .overflow(overflow_slow), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one line level for a number of cycles; always entered and left on a negedge.
    task automatic drive(input bit slow, input logic v, input int cycles);
        if (slow) rxd_slow = v;
        else      rxd = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Ideal 8N1 frame. pop_at_stop raises rready for exactly the mid-stop push cycle.
    task automatic send_frame(input bit slow, input logic [7:0] b, input logic stop_v,
                              input bit pop_at_stop);
        int h;
        h = slow ? HS : H;
        drive(slow, 1'b0, 2*h);
        for (int i = 0; i < 8; i++) drive(slow, b[i], 2*h);
        if (pop_at_stop) begin
            drive(slow, stop_v, h+2);
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
            drive(slow, stop_v, h-3);
        end else begin
            drive(slow, stop_v, 2*h);
        end
        if (slow) rxd_slow = 1'b1;
        else      rxd = 1'b1;
    endtask

    task automatic pulse_rready();
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rdata", 32'(rdata), 32'h00);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // 1: two frames, FWFT head, single pops, pop on empty ignored
        send_frame(0, 8'h55, 1'b1, 0);
        send_frame(0, 8'hA3, 1'b1, 0);
        chk("t1_level2", 32'(level), 32'd2);
        chk("t1_rvalid", 32'(rvalid), 32'h1);
        chk("t1_head55", 32'(rdata), 32'h55);
        pulse_rready();
        chk("t1_headA3", 32'(rdata), 32'hA3);
        chk("t1_level1", 32'(level), 32'd1);
        pulse_rready();
        chk("t1_empty_rvalid", 32'(rvalid), 32'h0);
        pulse_rready();
        chk("t1_pop_empty_level", 32'(level), 32'd0);

        // 2: start glitch shorter than half a bit is rejected
        drive(0, 1'b0, H-2);
        drive(0, 1'b1, 4*H);
        chk("t2_level", 32'(level), 32'd0);
        chk("t2_frame_err", 32'(frame_err), 32'h0);
        chk("t2_overflow", 32'(overflow), 32'h0);
        send_frame(0, 8'h81, 1'b1, 0);
        chk("t2_after_glitch", 32'(rdata), 32'h81);
        pulse_rready();

        // 3: bad stop bit sets frame_err, byte discarded; clear; then a good frame
        send_frame(0, 8'h3C, 1'b0, 0);
        drive(0, 1'b1, 4*H);
        chk("t3_frame_err", 32'(frame_err), 32'h1);
        chk("t3_level0", 32'(level), 32'd0);
        pulse_clr();
        chk("t3_cleared", 32'(frame_err), 32'h0);
        send_frame(0, 8'h3C, 1'b1, 0);
        chk("t3_rx3C", 32'(rdata), 32'h3C);
        chk("t3_level1", 32'(level), 32'd1);
        pulse_rready();

        // 4: 17 bytes into a 16-deep FIFO with no reads
        for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 1'b1, 0);
        chk("t4_level_full", 32'(level), 32'd16);
        chk("t4_overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_drain_%0d", i), 32'(rdata), 32'(i));
            pulse_rready();
        end
        chk("t4_end_rvalid", 32'(rvalid), 32'h0);
        chk("t4_end_level", 32'(level), 32'd0);
        pulse_clr();
        chk("t4_ovf_cleared", 32'(overflow), 32'h0);

        // 5: full FIFO, pop coincident with the 17th push
        for (int i = 0; i < 16; i++) send_frame(0, 8'(8'h20 + i), 1'b1, 0);
        chk("t5_level16_pre", 32'(level), 32'd16);
        send_frame(0, 8'h30, 1'b1, 1);
        chk("t5_no_overflow", 32'(overflow), 32'h0);
        chk("t5_level16", 32'(level), 32'd16);
        chk("t5_head21", 32'(rdata), 32'h21);
        for (int i = 0; i < 15; i++) pulse_rready();
        chk("t5_last30", 32'(rdata), 32'h30);
        chk("t5_level_last", 32'(level), 32'd1);
        pulse_rready();

        // 6: reset during data bit 4 with a byte queued and frame_err set
        send_frame(0, 8'h99, 1'b1, 0);
        send_frame(0, 8'h42, 1'b0, 0);
        drive(0, 1'b1, 4*H);
        chk("t6_pre_level", 32'(level), 32'd1);
        chk("t6_pre_ferr", 32'(frame_err), 32'h1);
        drive(0, 1'b0, 2*H);
        for (int i = 0; i < 4; i++) drive(0, 1'b0, 2*H);
        drive(0, 1'b0, H);
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_rdata", 32'(rdata), 32'h00);
        chk("t6_rst_rvalid", 32'(rvalid), 32'h0);
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_ferr", 32'(frame_err), 32'h0);
        rstn = 1'b1;
        drive(0, 1'b1, 4*H);
        chk("t6_idle_level", 32'(level), 32'd0);
        send_frame(0, 8'hE7, 1'b1, 0);
        chk("t6_rxE7", 32'(rdata), 32'hE7);
        chk("t6_level1", 32'(level), 32'd1);
        chk("t6_no_ferr", 32'(frame_err), 32'h0);

        // Latency at default timing: start edge to rvalid is 19*HS + 3 cycles here
        cnt = 0;
        fork
            send_frame(1, 8'h55, 1'b1, 0);
            begin
                do begin
                    @(negedge clk);
                    cnt++;
                end while (!rvalid_slow && cnt < 20000);
            end
        join
        chk("slow_rvalid", 32'(rvalid_slow), 32'h1);
        chk("slow_rx55", 32'(rdata_slow), 32'h55);
        chk("slow_latency_in_window",
            32'(cnt >= 19*HS + 3 && cnt <= 19*HS + 5), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
